// File: rtl/store_pkg.sv
// store_pkg: shared types and constants for the store alignment path.
package store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;
  localparam logic [2:0] STORE_SD = 3'b011;

  // Store width is legal when funct3[2] is clear and sd is only used on 64-bit datapaths
  function automatic logic width_legal(input logic [2:0] funct3, input int unsigned xlen);
    logic ok;
    ok = 1'b1;
    if (funct3[2]) ok = 1'b0;
    if ((funct3 == STORE_SD) && (xlen != 32'd64)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/store_mask_gen.sv
// store_mask_gen: combinational byte-enable and lane-shift generator.
// Produces a two-word mask/data window; the upper word is the spill into the next word.
module store_mask_gen
  import store_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                    funct3,
  input  logic [$clog2(XLEN/8)-1:0]     offset,
  input  logic [XLEN-1:0]               wdata,
  output logic [2*(XLEN/8)-1:0]         mask,
  output logic [2*XLEN-1:0]             data,
  output logic                          illegal
);

  localparam int unsigned NB = XLEN / 8;

  logic [NB-1:0]   low_mask;
  logic [XLEN-1:0] trimmed;

  // Build the unshifted byte mask, drop bytes above the store size, then shift into lanes
  always_comb begin
    illegal  = !width_legal(funct3, XLEN);
    low_mask = '0;
    trimmed  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      low_mask[i] = (i < (32'd1 << funct3[1:0]));
      if (low_mask[i]) trimmed[i*8 +: 8] = wdata[i*8 +: 8];
    end
    mask = {{NB{1'b0}}, low_mask} << offset;
    data = {{XLEN{1'b0}}, trimmed} << {offset, 3'b000};
  end

endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: turns sb/sh/sw/sd requests into word-aligned memory beats.
// Macro STORE_MISALIGNED_SPLIT_EN: when defined, word-crossing stores issue a
// second beat; when undefined they are rejected with store_fault.
module store_align_unit
  import store_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              store_fault,
  output logic              busy
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  state_t state, state_nxt;

  logic [2*NB-1:0]   gen_mask;
  logic [2*XLEN-1:0] gen_data;
  logic              gen_illegal;
  logic              accept;
  logic              reject;

  store_mask_gen #(.XLEN(XLEN)) u_mask_gen (
    .funct3  (req_funct3),
    .offset  (req_addr[OFFW-1:0]),
    .wdata   (req_wdata),
    .mask    (gen_mask),
    .data    (gen_data),
    .illegal (gen_illegal)
  );

  assign accept = req_valid && req_ready;

`ifdef STORE_MISALIGNED_SPLIT_EN
  logic [NB-1:0]   hi_be;
  logic [XLEN-1:0] hi_data;
  assign reject = gen_illegal;
`else
  assign reject = gen_illegal || (|gen_mask[2*NB-1:NB]);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !reject) state_nxt = BEAT0;
      end
      BEAT0: begin
        if (mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
          state_nxt = (|hi_be) ? BEAT1 : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef STORE_MISALIGNED_SPLIT_EN
      BEAT1: begin
        if (mem_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_valid = (state == BEAT0) || (state == BEAT1);
  end

  // Beat registers: load beat0 on accept, beat1 after beat0 handshake, clear on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      store_fault <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
      hi_be       <= '0;
      hi_data     <= '0;
`endif
    end else begin
      store_fault <= accept && reject;
      if (accept && !reject) begin
        mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        mem_be    <= gen_mask[NB-1:0];
        mem_wdata <= gen_data[XLEN-1:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
        hi_be     <= gen_mask[2*NB-1:NB];
        hi_data   <= gen_data[2*XLEN-1:XLEN];
`endif
      end else if (mem_valid && mem_ready) begin
        if (state_nxt == BEAT1) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
          mem_addr  <= mem_addr + XLEN'(NB);
          mem_be    <= hi_be;
          mem_wdata <= hi_data;
`endif
        end else begin
          mem_addr  <= '0;
          mem_be    <= '0;
          mem_wdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: scoreboard bench for store_align_unit (XLEN=32 main, XLEN=64 side).
module tb_store_align_unit;

`ifdef STORE_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        store_fault, busy;

  logic        v64, r64_ready, m64_valid, m64_ready, f64, b64;
  logic [2:0]  f3_64;
  logic [63:0] a64, w64, ma64, md64;
  logic [7:0]  be64;

  store_align_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .store_fault(store_fault), .busy(busy)
  );

  store_align_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(r64_ready),
    .req_funct3(f3_64), .req_addr(a64), .req_wdata(w64),
    .mem_valid(m64_valid), .mem_ready(m64_ready), .mem_addr(ma64),
    .mem_wdata(md64), .mem_be(be64), .store_fault(f64), .busy(b64)
  );

  typedef struct packed {
    logic        fault;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Scoreboard monitor: every fault pulse and every beat handshake consumes one expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (store_fault) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_fault got=unexpected fault expected=nothing");
        end else begin
          mon_e = q.pop_front();
          if (mon_e.fault !== 1'b1) begin
            failures++;
            $display("FAIL sb_fault got=fault expected=beat addr=%h be=%b data=%h",
                     mon_e.addr, mon_e.be, mon_e.data);
          end
        end
      end
      if (mem_valid && mem_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_beat got=addr=%h be=%b data=%h expected=nothing",
                   mem_addr, mem_be, mem_wdata);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.fault || mem_addr !== mon_e.addr || mem_be !== mon_e.be ||
              mem_wdata !== mon_e.data) begin
            failures++;
            $display("FAIL sb_beat got=addr=%h be=%b data=%h expected=fault=%0b addr=%h be=%b data=%h",
                     mem_addr, mem_be, mem_wdata, mon_e.fault, mon_e.addr, mon_e.be, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic f, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.fault = f; e.addr = a; e.be = be; e.data = d;
    q.push_back(e);
  endtask

  // Byte-by-byte reference model of one store request
  task automatic push_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0]  be2;
    logic [63:0] d2;
    logic [31:0] base;
    int unsigned size, off, lane;
    be2 = '0; d2 = '0;
    base = {a[31:2], 2'b00};
    if (f3[2] || f3[1:0] == 2'b11) begin
      push(1'b1, '0, '0, '0);
    end else begin
      size = 32'd1 << f3[1:0];
      off  = {30'd0, a[1:0]};
      for (int unsigned i = 0; i < size; i++) begin
        lane = off + i;
        be2[lane] = 1'b1;
        d2[lane*8 +: 8] = wd[i*8 +: 8];
      end
      if (be2[7:4] != 4'b0 && !SPLIT) begin
        push(1'b1, '0, '0, '0);
      end else begin
        push(1'b0, base, be2[3:0], d2[31:0]);
        if (be2[7:4] != 4'b0) push(1'b0, base + 32'd4, be2[7:4], d2[63:32]);
      end
    end
  endtask

  // Present a request, hold it until accepted; returns #1 after the accepting edge
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL send_wait got=req_ready=0 expected=req_ready=1 within 200 cycles");
      req_valid = 1'b0;
    end else begin
      tick();
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain got=pending=%0d busy=%b expected=pending=0 busy=0", q.size(), busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
      failures++;
      $display("FAIL reset_beat got=v=%b a=%h d=%h be=%b expected=all zero", mem_valid, mem_addr, mem_wdata, mem_be);
    end
    checks++;
    if (store_fault !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_status got=fault=%b busy=%b ready=%b expected=0 0 1", store_fault, busy, req_ready);
    end
  endtask

  task automatic test_byte;
    mem_ready = 1'b1;
    push(1'b0, 32'h1000, 4'b1000, 32'hAB000000);
    send(3'b000, 32'h1003, 32'h000000AB);
    checks++;
    if (mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL sb_latency got=mem_valid=%b expected=1", mem_valid);
    end
    wait_drain();
    checks++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL sb_idle got=v=%b ready=%b expected=0 1", mem_valid, req_ready);
    end
    // upper bytes of wdata must be ignored
    push(1'b0, 32'h1000, 4'b0010, 32'h0000CD00);
    send(3'b000, 32'h1001, 32'h123456CD);
    wait_drain();
  endtask

  task automatic test_stall;
    mem_ready = 1'b0;
    push(1'b0, 32'h2000, 4'b1111, 32'hDEADBEEF);
    send(3'b010, 32'h2000, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_be !== 4'b1111 ||
          mem_wdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got=v=%b a=%h be=%b d=%h ready=%b expected=1 00002000 1111 deadbeef 0",
                 mem_valid, mem_addr, mem_be, mem_wdata, req_ready);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drop got=mem_valid=%b expected=0", mem_valid);
    end
    wait_drain();
  endtask

  task automatic test_cross;
    mem_ready = 1'b1;
    if (SPLIT) begin
      push(1'b0, 32'h1000, 4'b1100, 32'h33440000);
      push(1'b0, 32'h1004, 4'b0011, 32'h00001122);
    end else begin
      push(1'b1, '0, '0, '0);
    end
    send(3'b010, 32'h1002, 32'h11223344);
    if (SPLIT) begin
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h1004 || mem_be !== 4'b0011) begin
        failures++;
        $display("FAIL split_beat1 got=v=%b a=%h be=%b expected=1 00001004 0011", mem_valid, mem_addr, mem_be);
      end
    end else begin
      checks++;
      if (store_fault !== 1'b1 || mem_valid !== 1'b0) begin
        failures++;
        $display("FAIL nosplit_fault got=fault=%b v=%b expected=1 0", store_fault, mem_valid);
      end
      tick();
      checks++;
      if (store_fault !== 1'b0 || mem_valid !== 1'b0) begin
        failures++;
        $display("FAIL nosplit_pulse got=fault=%b v=%b expected=0 0", store_fault, mem_valid);
      end
    end
    wait_drain();
    if (SPLIT) begin
      push(1'b0, 32'h1000, 4'b1000, 32'hEF000000);
      push(1'b0, 32'h1004, 4'b0001, 32'h000000BE);
    end else begin
      push(1'b1, '0, '0, '0);
    end
    send(3'b001, 32'h1003, 32'h0000BEEF);
    wait_drain();
  endtask

  task automatic test_illegal;
    logic [2:0] ill [3];
    ill[0] = 3'b011; ill[1] = 3'b100; ill[2] = 3'b111;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, '0, '0, '0);
      send(ill[k], 32'h3000, 32'hFFFFFFFF);
      checks++;
      if (store_fault !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_%0d got=fault=%b v=%b busy=%b expected=1 0 0", k, store_fault, mem_valid, busy);
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_back_to_back;
    time t0, t1;
    bit  done;
    mem_ready = 1'b1;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 32'h4000 + 32'(k*4), 4'b1111, 32'hA5A50000 + 32'(k));
      send(3'b010, 32'h4000 + 32'(k*4), 32'hA5A50000 + 32'(k));
      if (k == 0) t0 = $time;
    end
    t1 = $time;
    checks++;
    if (t1 - t0 !== 60) begin
      failures++;
      $display("FAIL throughput got=%0t expected=60 between first and fourth accept", t1 - t0);
    end
    wait_drain();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [2:0]  f3;
          logic [31:0] a, wd;
          f3 = 3'($urandom_range(0, 3));
          a  = (k % 5 == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
          wd = $urandom;
          push_model(f3, a, wd);
          send(f3, a, wd);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          mem_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    mem_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b1;
    if (SPLIT) begin
      push(1'b0, 32'h1000, 4'b1100, 32'h33440000);
      send(3'b010, 32'h1002, 32'h11223344);
      tick();
      mem_ready = 1'b0;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h1004) begin
        failures++;
        $display("FAIL mid_beat1 got=v=%b a=%h expected=1 00001004", mem_valid, mem_addr);
      end
    end else begin
      mem_ready = 1'b0;
      send(3'b010, 32'h2000, 32'h12345678);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || mem_be !== 4'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || store_fault !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=v=%b busy=%b ready=%b be=%b a=%h d=%h f=%b expected=0 0 1 0 0 0 0",
               mem_valid, busy, req_ready, mem_be, mem_addr, mem_wdata, store_fault);
    end
    reset = 1'b0;
    q.delete();
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic send64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n;
    n = 0;
    v64 = 1'b1; f3_64 = f3; a64 = a; w64 = wd;
    while (!r64_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    v64 = 1'b0;
  endtask

  task automatic test_xlen64;
    m64_ready = 1'b1;
    send64(3'b011, 64'h40, 64'h0102030405060708);
    checks++;
    if (m64_valid !== 1'b1 || ma64 !== 64'h40 || be64 !== 8'hFF ||
        md64 !== 64'h0102030405060708 || f64 !== 1'b0) begin
      failures++;
      $display("FAIL x64_sd got=v=%b a=%h be=%h d=%h f=%b expected=1 40 ff 0102030405060708 0",
               m64_valid, ma64, be64, md64, f64);
    end
    tick();
    checks++;
    if (m64_valid !== 1'b0) begin
      failures++;
      $display("FAIL x64_single got=v=%b expected=0", m64_valid);
    end
    send64(3'b001, 64'h46, 64'hFFFFFFFFFFFFABCD);
    checks++;
    if (m64_valid !== 1'b1 || ma64 !== 64'h40 || be64 !== 8'hC0 || md64 !== 64'hABCD000000000000) begin
      failures++;
      $display("FAIL x64_sh got=v=%b a=%h be=%h d=%h expected=1 40 c0 abcd000000000000",
               m64_valid, ma64, be64, md64);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
    v64 = 1'b0; f3_64 = '0; a64 = '0; w64 = '0; m64_ready = 1'b1;
    tick();
    test_reset();
    test_byte();
    test_stall();
    test_cross();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_xlen64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
